// File: rtl/memory_stage_pkg.sv
// Shared constants and types for the MEM stage; carries the same widths and
// load/store opcodes the decode and execute stages use.
//   DWIDTH       data/address width
//   OPCODE_WIDTH opcode width
//   AWIDTH       register-file address width
package memory_stage_pkg;

    localparam int unsigned DWIDTH       = 32;
    localparam int unsigned OPCODE_WIDTH = 6;
    localparam int unsigned AWIDTH       = 5;
    localparam int unsigned BE_WIDTH     = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
    localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
    localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Data-memory request payload
    typedef struct packed {
        logic                we;
        logic [DWIDTH-1:0]   addr;
        logic [DWIDTH-1:0]   wdata;
        logic [BE_WIDTH-1:0] be;
    } dmem_req_t;

    // Writeback payload
    typedef struct packed {
        logic [DWIDTH-1:0] value;
        logic [AWIDTH-1:0] rd_addr;
        logic              reg_write;
        logic              misalign;
    } wb_t;

    function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [OPCODE_WIDTH-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0
    function automatic logic misaligned(input logic [OPCODE_WIDTH-1:0] op,
                                        input logic [1:0]              lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // Word address, lane-replicated store data and byte enables
    function automatic dmem_req_t build_request(input logic [OPCODE_WIDTH-1:0] op,
                                                input logic [DWIDTH-1:0]       addr,
                                                input logic [DWIDTH-1:0]       rt);
        dmem_req_t r;
        r.we    = is_store(op);
        r.addr  = {addr[DWIDTH-1:2], 2'b00};
        r.wdata = rt;
        r.be    = 4'b1111;
        case (op)
            OP_SB: begin
                r.be    = 4'(4'b0001 << addr[1:0]);
                r.wdata = {4{rt[7:0]}};
            end
            OP_SH: begin
                r.be    = addr[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{rt[15:0]}};
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_format.sv
// Load data formatter: picks the byte/halfword lane named by the low address
// bits and sign- or zero-extends it; words pass through unchanged.
// Purely combinational so a cache refill path can share it.
//   opcode   load opcode
//   addr_lo  address bits [1:0]
//   rdata    raw memory word
//   value_c  formatted register value
module load_format
    import memory_stage_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [1:0]              addr_lo,
    input  logic [DWIDTH-1:0]       rdata,
    output logic [DWIDTH-1:0]       value_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        value_c = rdata;
        case (opcode)
            OP_LB:   value_c = {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
            OP_LBU:  value_c = {{(DWIDTH-8){1'b0}}, byte_lane};
            OP_LH:   value_c = {{(DWIDTH-16){half_lane[15]}}, half_lane};
            OP_LHU:  value_c = {{(DWIDTH-16){1'b0}}, half_lane};
            default: value_c = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding, and retires one registered
// writeback per instruction. Non-memory ops pass through in one cycle.
// Optional build macro MS_MISALIGN_CHECK_EN: misaligned half/word accesses
// retire immediately with ms_o_misalign=1 and no memory request.
// Ports:
//   ms_i_clk, ms_i_rst            clock, async active-low reset
//   ms_i_ce .. ms_i_reg_write     instruction from execute
//   ms_o_stall                    hold upstream (combinational)
//   ms_o_dmem_*, ms_i_dmem_*      data-memory request/ack port
//   ms_o_ce .. ms_o_misalign      registered writeback
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                    ms_i_clk,
    input  logic                    ms_i_rst,
    input  logic                    ms_i_ce,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [DWIDTH-1:0]       ms_i_alu_value,
    input  logic [DWIDTH-1:0]       ms_i_data_rt,
    input  logic [AWIDTH-1:0]       ms_i_rd_addr,
    input  logic                    ms_i_reg_write,
    output logic                    ms_o_stall,
    output logic                    ms_o_dmem_req,
    output logic                    ms_o_dmem_we,
    output logic [DWIDTH-1:0]       ms_o_dmem_addr,
    output logic [DWIDTH-1:0]       ms_o_dmem_wdata,
    output logic [BE_WIDTH-1:0]     ms_o_dmem_be,
    input  logic                    ms_i_dmem_ack,
    input  logic [DWIDTH-1:0]       ms_i_dmem_rdata,
    output logic                    ms_o_ce,
    output logic [DWIDTH-1:0]       ms_o_value,
    output logic [AWIDTH-1:0]       ms_o_rd_addr,
    output logic                    ms_o_reg_write,
    output logic                    ms_o_misalign
);

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] lat_op;
    logic [1:0]              lat_lo;
    logic [AWIDTH-1:0]       lat_rd;
    logic                    lat_rw;

    // One-entry skid for a result accepted on an edge whose output slot is
    // already taken (ack retirement, or a previous skid entry draining).
    wb_t                     skid;
    logic                    skid_valid;

    logic                    misalign_c;
    logic                    ack_retire_c;
    logic                    accept_c;
    logic                    accept_mem_c;
    logic                    accept_wb_c;
    logic                    out_load_c;
    logic                    skid_load_c;
    dmem_req_t               req_c;
    wb_t                     new_wb_c;
    wb_t                     ack_wb_c;
    wb_t                     out_wb_c;
    logic [DWIDTH-1:0]       load_value_c;

`ifdef MS_MISALIGN_CHECK_EN
    assign misalign_c = misaligned(ms_i_opcode, ms_i_alu_value[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Low on the ack cycle so the next instruction is taken on the completing edge
    assign ms_o_stall = (state == ST_ACCESS) && !ms_i_dmem_ack;

    load_format u_load_format (
        .opcode  (lat_op),
        .addr_lo (lat_lo),
        .rdata   (ms_i_dmem_rdata),
        .value_c (load_value_c)
    );

    // Acceptance, retirement and writeback selection
    always_comb begin
        req_c        = build_request(ms_i_opcode, ms_i_alu_value, ms_i_data_rt);
        ack_retire_c = (state == ST_ACCESS) && ms_i_dmem_ack;
        accept_c     = ms_i_ce && ((state == ST_IDLE) || ack_retire_c);
        accept_mem_c = accept_c && is_mem(ms_i_opcode) && !misalign_c;
        accept_wb_c  = accept_c && !accept_mem_c;

        new_wb_c.value     = misalign_c ? '0 : ms_i_alu_value;
        new_wb_c.rd_addr   = ms_i_rd_addr;
        new_wb_c.reg_write = ms_i_reg_write && !misalign_c;
        new_wb_c.misalign  = misalign_c;

        ack_wb_c.value     = is_load(lat_op) ? load_value_c : '0;
        ack_wb_c.rd_addr   = lat_rd;
        ack_wb_c.reg_write = is_load(lat_op) && lat_rw;
        ack_wb_c.misalign  = 1'b0;

        out_load_c  = skid_valid || ack_retire_c || accept_wb_c;
        skid_load_c = accept_wb_c && (skid_valid || ack_retire_c);

        if (skid_valid) begin
            out_wb_c = skid;
        end else if (ack_retire_c) begin
            out_wb_c = ack_wb_c;
        end else begin
            out_wb_c = new_wb_c;
        end
    end

    // State, memory port and writeback registers
    always_ff @(posedge ms_i_clk or negedge ms_i_rst) begin
        if (!ms_i_rst) begin
            state           <= ST_IDLE;
            lat_op          <= '0;
            lat_lo          <= '0;
            lat_rd          <= '0;
            lat_rw          <= 1'b0;
            skid            <= '0;
            skid_valid      <= 1'b0;
            ms_o_dmem_req   <= 1'b0;
            ms_o_dmem_we    <= 1'b0;
            ms_o_dmem_addr  <= '0;
            ms_o_dmem_wdata <= '0;
            ms_o_dmem_be    <= '0;
            ms_o_ce         <= 1'b0;
            ms_o_value      <= '0;
            ms_o_rd_addr    <= '0;
            ms_o_reg_write  <= 1'b0;
            ms_o_misalign   <= 1'b0;
        end else begin
            ms_o_ce       <= out_load_c;
            ms_o_misalign <= out_load_c && out_wb_c.misalign;
            if (out_load_c) begin
                ms_o_value     <= out_wb_c.value;
                ms_o_rd_addr   <= out_wb_c.rd_addr;
                ms_o_reg_write <= out_wb_c.reg_write;
            end

            skid_valid <= skid_load_c;
            if (skid_load_c) begin
                skid <= new_wb_c;
            end

            case (state)
                ST_IDLE: begin
                    if (accept_mem_c) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (ack_retire_c && !accept_mem_c) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept_mem_c) begin
                lat_op          <= ms_i_opcode;
                lat_lo          <= ms_i_alu_value[1:0];
                lat_rd          <= ms_i_rd_addr;
                lat_rw          <= ms_i_reg_write;
                ms_o_dmem_req   <= 1'b1;
                ms_o_dmem_we    <= req_c.we;
                ms_o_dmem_addr  <= req_c.addr;
                ms_o_dmem_wdata <= req_c.wdata;
                ms_o_dmem_be    <= req_c.be;
            end else if (ack_retire_c) begin
                ms_o_dmem_req   <= 1'b0;
            end
        end
    end

endmodule
